fp_div_arbiter: RTL

FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

---
 rtl/div_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/fp_div_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and widths for the FP32 divider arbiter.
package div_arb_pkg;

  localparam int FP_W  = 32;
  localparam int ST_W  = 8;
  localparam int RND_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: scan upward from ptr with wrap, first valid wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int sum;
  logic [IW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = 0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      pos = IW'(sum);
      if (!any && valid[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one sequential FP32 divider among N requesters with round-robin
// arbitration, a busy-timeout abort and a held response per owner.
module fp_div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*FP_W-1:0] req_a,
  input  logic [N*FP_W-1:0] req_b,
  input  logic [RND_W-1:0]  cfg_rnd,
  output logic [N-1:0]      rsp_valid,
  input  logic [N-1:0]      rsp_ready,
  output logic [FP_W-1:0]   rsp_z,
  output logic [ST_W-1:0]   rsp_status,
  output logic              rsp_err,
  output logic              div_start,
  output logic [FP_W-1:0]   div_a,
  output logic [FP_W-1:0]   div_b,
  output logic [RND_W-1:0]  div_rnd,
  input  logic              div_complete,
  input  logic [FP_W-1:0]   div_z,
  input  logic [ST_W-1:0]   div_status,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   cnt;
  logic [FP_W-1:0] op_a;
  logic [FP_W-1:0] op_b;
  logic [RND_W-1:0] op_rnd;

  logic [N-1:0]  grant;
  logic [IW-1:0] win_idx;
  logic          win_any;

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready. req_ready is offered only in IDLE,
  // rsp_valid only for the owner in RESP, and rsp_* stay frozen until taken.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (!rst && state == S_IDLE) req_ready = grant;
    if (state == S_RESP) rsp_valid[owner] = 1'b1;
  end

  assign div_start = (state == S_START);
  assign div_a     = op_a;
  assign div_b     = op_b;
  assign div_rnd   = op_rnd;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_rnd     <= '0;
      rsp_z      <= '0;
      rsp_status <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_any) begin
            op_a   <= req_a[win_idx*FP_W +: FP_W];
            op_b   <= req_b[win_idx*FP_W +: FP_W];
            op_rnd <= cfg_rnd;
            owner  <= win_idx;
            state  <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_BUSY;
        end
        // Complete is looked at only here, so one left high from the previous
        // operation cannot be mistaken for this one's result.
        S_BUSY: begin
          cnt <= cnt + 1'b1;
          if (div_complete) begin
            rsp_z      <= div_z;
            rsp_status <= div_status;
            rsp_err    <= 1'b0;
            state      <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_z      <= '0;
            rsp_status <= '0;
            rsp_err    <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[owner]) begin
            ptr   <= (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
